// File: rtl/fetch_pack_stage.sv
// Fetch packing stage: walks the PC, fetches one aligned line at a time and pushes
// its instructions, compacted from port 0, into the decode FIFO. Option: FETCH_RSP_BYPASS_EN.
module fetch_pack_stage #(
    parameter int                    PORT_NUM   = 2,
    parameter int                    INST_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    output logic                                            bus_req_valid,
    input  logic                                            bus_req_ready,
    output logic [ADDR_WIDTH-1:0]                           bus_req_addr,
    input  logic                                            bus_rsp_valid,
    input  logic [PORT_NUM*INST_WIDTH-1:0]                  bus_rsp_data,
    input  logic                                            redirect_valid,
    input  logic [ADDR_WIDTH-1:0]                           redirect_pc,
    output logic [0:PORT_NUM-1][ADDR_WIDTH+INST_WIDTH-1:0]  fifo_data_in,
    output logic [PORT_NUM-1:0]                             fifo_data_in_valid,
    input  logic [PORT_NUM-1:0]                             fifo_data_in_enable,
    output logic                                            fifo_push,
    input  logic                                            fifo_full,
    output logic                                            fifo_flush
);

    localparam int SW         = $clog2(PORT_NUM);
    localparam int CW         = SW + 1;
    localparam int LINE_SHIFT = SW + 2;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << LINE_SHIFT) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          pc_q, pc_d;
    logic [PORT_NUM*INST_WIDTH-1:0] line_q, line_d;
    logic [SW-1:0]                  slot_q, slot_d;

    logic [ADDR_WIDTH-1:0]          line_addr;
    logic [PORT_NUM*INST_WIDTH-1:0] src_line;
    logic [SW-1:0]                  src_slot;
    logic                           src_act;
    logic [CW-1:0]                  pending;
    logic [CW-1:0]                  accepted;
    logic [CW-1:0]                  slot_sum;
    logic                           line_done;
    int                             idx;

    assign line_addr     = pc_q & LINE_MASK;
    assign bus_req_addr  = line_addr;
    assign bus_req_valid = (state_q == S_REQ) && !redirect_valid;
    assign fifo_flush    = redirect_valid;

    // Push datapath: the source is the held line, or the live response when bypassing.
    always_comb begin
        src_line           = line_q;
        src_slot           = slot_q;
        src_act            = (state_q == S_HOLD);
`ifdef FETCH_RSP_BYPASS_EN
        if (state_q == S_WAIT && bus_rsp_valid) begin
            src_line = bus_rsp_data;
            src_slot = pc_q[LINE_SHIFT-1:2];
            src_act  = 1'b1;
        end
`endif
        pending            = CW'(PORT_NUM) - {1'b0, src_slot};
        fifo_data_in_valid = '0;
        fifo_data_in       = '0;
        accepted           = '0;
        idx                = 0;
        for (int k = 0; k < PORT_NUM; k++) begin
            if (src_act && (CW'(k) < pending)) begin
                idx                   = int'(src_slot) + k;
                fifo_data_in_valid[k] = 1'b1;
                fifo_data_in[k]       = {line_addr + ADDR_WIDTH'(4 * idx),
                                         src_line[idx*INST_WIDTH +: INST_WIDTH]};
            end
        end
        for (int k = 0; k < PORT_NUM; k++) begin
            accepted = accepted + {{SW{1'b0}}, fifo_data_in_valid[k] & fifo_data_in_enable[k]};
        end
        fifo_push = src_act && !fifo_full && !redirect_valid;
        slot_sum  = {1'b0, src_slot} + accepted;
        line_done = (slot_sum == CW'(PORT_NUM));
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        line_d  = line_q;
        slot_d  = slot_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus_req_valid && bus_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus_rsp_valid) begin
                    line_d  = bus_rsp_data;
                    slot_d  = pc_q[LINE_SHIFT-1:2];
                    state_d = S_HOLD;
                end
            end
            S_HOLD: state_d = S_HOLD;
            S_DROP: begin
                if (bus_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        if (fifo_push) begin
            if (line_done) begin
                pc_d    = line_addr + ADDR_WIDTH'(PORT_NUM * 4);
                state_d = S_REQ;
            end else begin
                slot_d  = SW'(slot_sum);
                state_d = S_HOLD;
            end
        end

        // A redirect must not let a new request overtake a response still in flight.
        if (redirect_valid) begin
            pc_d = redirect_pc & ~ADDR_WIDTH'(3);
            if ((state_q == S_WAIT || state_q == S_DROP) && !bus_rsp_valid)
                state_d = S_DROP;
            else
                state_d = S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            line_q  <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            line_q  <= line_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: tb/tb_fetch_pack_stage.sv
// Bench for fetch_pack_stage: directed scenarios, then a random bus/FIFO run checked
// against an instruction-stream model (next expected pc, inst derived from pc).
module tb_fetch_pack_stage;

    localparam int PN = 4;
    localparam int IW = 32;
    localparam int AW = 32;
    localparam int EW = AW + IW;
    localparam logic [AW-1:0] RPC = 32'h8000_0000;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      bus_req_valid;
    logic                      bus_req_ready;
    logic [AW-1:0]             bus_req_addr;
    logic                      bus_rsp_valid;
    logic [PN*IW-1:0]          bus_rsp_data;
    logic                      redirect_valid;
    logic [AW-1:0]             redirect_pc;
    logic [0:PN-1][EW-1:0]     fifo_data_in;
    logic [PN-1:0]             fifo_data_in_valid;
    logic [PN-1:0]             fifo_data_in_enable;
    logic                      fifo_push;
    logic                      fifo_full;
    logic                      fifo_flush;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pack_stage #(
        .PORT_NUM  (PN),
        .INST_WIDTH(IW),
        .ADDR_WIDTH(AW),
        .RESET_PC  (RPC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .bus_req_valid      (bus_req_valid),
        .bus_req_ready      (bus_req_ready),
        .bus_req_addr       (bus_req_addr),
        .bus_rsp_valid      (bus_rsp_valid),
        .bus_rsp_data       (bus_rsp_data),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .fifo_data_in       (fifo_data_in),
        .fifo_data_in_valid (fifo_data_in_valid),
        .fifo_data_in_enable(fifo_data_in_enable),
        .fifo_push          (fifo_push),
        .fifo_full          (fifo_full),
        .fifo_flush         (fifo_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [PN*IW-1:0] line_data(input logic [AW-1:0] a);
        logic [PN*IW-1:0] d;
        d = '0;
        for (int k = 0; k < PN; k++) d[k*IW +: IW] = inst_of(a + AW'(4 * k));
        return d;
    endfunction

    // Advance to the next sampling window with every input back at its idle value.
    task automatic next_cycle();
        @(negedge clk);
        bus_req_ready       = 1'b0;
        bus_rsp_valid       = 1'b0;
        bus_rsp_data        = '0;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        fifo_full           = 1'b0;
        fifo_data_in_enable = '1;
    endtask

    task automatic handshake(input string tag, input logic [AW-1:0] addr);
        next_cycle();
        bus_req_ready = 1'b1;
        #1;
        chk({tag, "_req_valid"}, bus_req_valid, 1'b1);
        chk({tag, "_req_addr"}, bus_req_addr, addr);
    endtask

    // Returns positioned in the cycle where the line should be pushed.
    task automatic rsp_cycle(input string tag, input logic [AW-1:0] a,
                             input logic [PN-1:0] en, input logic full);
        next_cycle();
        bus_rsp_valid       = 1'b1;
        bus_rsp_data        = line_data(a);
        fifo_data_in_enable = en;
        fifo_full           = full;
        #1;
`ifndef FETCH_RSP_BYPASS_EN
        chk({tag, "_rsp_no_push"}, fifo_push, 1'b0);
        next_cycle();
        fifo_data_in_enable = en;
        fifo_full           = full;
        #1;
`endif
    endtask

    task automatic check_push(input string tag, input logic [PN-1:0] vmask,
                              input logic [AW-1:0] pc0);
        chk({tag, "_push"}, fifo_push, 1'b1);
        chk({tag, "_valid"}, fifo_data_in_valid, vmask);
        for (int k = 0; k < PN; k++)
            if (vmask[k])
                chk({tag, "_entry"}, fifo_data_in[k], {pc0 + AW'(4 * k), inst_of(pc0 + AW'(4 * k))});
    endtask

    logic [AW-1:0] exp_pc;
    logic [AW-1:0] out_addr;
    logic [AW-1:0] rpc;
    logic [PN-1:0] v;
    int            outst, rcnt, nen, since_acc, max_gap, total_acc;

    initial begin
        rst_n               = 1'b0;
        bus_req_ready       = 1'b0;
        bus_rsp_valid       = 1'b0;
        bus_rsp_data        = '0;
        redirect_valid      = 1'b0;
        redirect_pc         = '0;
        fifo_full           = 1'b0;
        fifo_data_in_enable = '1;

        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_req_valid", bus_req_valid, 1'b0);
            chk("rst_push", fifo_push, 1'b0);
            chk("rst_data_valid", fifo_data_in_valid, '0);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("idle_req_valid", bus_req_valid, 1'b0);

        // full-line accept
        handshake("first", RPC);
        rsp_cycle("full", RPC, 4'b1111, 1'b0);
        check_push("full", 4'b1111, RPC);

        // partial accept then remainder
        handshake("next_line", 32'h8000_0010);
        rsp_cycle("part", 32'h8000_0010, 4'b0011, 1'b0);
        check_push("part_a", 4'b1111, 32'h8000_0010);
        next_cycle();
        #1;
        check_push("part_b", 4'b0011, 32'h8000_0018);

        // redirect while waiting: the in-flight response is dropped
        handshake("after_part", 32'h8000_0020);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0024;
        #1;
        chk("redir_flush", fifo_flush, 1'b1);
        chk("redir_push", fifo_push, 1'b0);
        chk("redir_req", bus_req_valid, 1'b0);
        next_cycle();
        #1;
        chk("drop_req", bus_req_valid, 1'b0);
        chk("drop_flush", fifo_flush, 1'b0);
        next_cycle();
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = {PN{32'hDEAD_BEEF}};
        #1;
        chk("drop_rsp_push", fifo_push, 1'b0);
        chk("drop_rsp_req", bus_req_valid, 1'b0);
        handshake("redir_line", 32'h8000_0020);
        rsp_cycle("redir", 32'h8000_0020, 4'b1111, 1'b0);
        check_push("redir", 4'b0111, 32'h8000_0024);

        // redirect coincident with the response
        handshake("pre_coinc", 32'h8000_0030);
        next_cycle();
        bus_rsp_valid  = 1'b1;
        bus_rsp_data   = line_data(32'h8000_0030);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        #1;
        chk("coinc_flush", fifo_flush, 1'b1);
        chk("coinc_push", fifo_push, 1'b0);
        handshake("coinc_line", 32'h8000_0100);

        // FIFO full stalls the push
        rsp_cycle("stall", 32'h8000_0100, 4'b1111, 1'b1);
        chk("stall_push", fifo_push, 1'b0);
        next_cycle();
        #1;
        check_push("stall_release", 4'b1111, 32'h8000_0100);
        next_cycle();
        #1;
        chk("stall_next_req", bus_req_valid, 1'b1);
        chk("stall_next_addr", bus_req_addr, 32'h8000_0110);

        // random run against the instruction-stream model
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n     = 1'b1;
        exp_pc    = RPC;
        outst     = 0;
        rcnt      = 0;
        out_addr  = '0;
        since_acc = 0;
        max_gap   = 0;
        total_acc = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            next_cycle();
            if (outst != 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_data  = line_data(out_addr);
                end
            end
            bus_req_ready  = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 + AW'(4 * $urandom_range(0, 3));
            else                           rpc = 32'h8000_0000 + AW'($urandom_range(0, 4095));
            redirect_pc         = rpc;
            fifo_full           = ($urandom_range(0, 9) == 0);
            nen                 = $urandom_range(0, PN);
            fifo_data_in_enable = PN'((1 << nen) - 1);
            #1;
            chk("rnd_flush", fifo_flush, redirect_valid);
            if (bus_rsp_valid) outst = 0;
            if (redirect_valid) begin
                chk("rnd_redir_push", fifo_push, 1'b0);
                chk("rnd_redir_req", bus_req_valid, 1'b0);
                exp_pc = rpc & ~AW'(3);
            end
            since_acc++;
            if (fifo_push) begin
                v = fifo_data_in_valid;
                chk("rnd_valid_contig", (v != 0) && (((v + 1'b1) & v) == 0), 1'b1);
                for (int k = 0; k < PN; k++) begin
                    if (v[k] && fifo_data_in_enable[k]) begin
                        chk("rnd_entry", fifo_data_in[k], {exp_pc, inst_of(exp_pc)});
                        exp_pc    = exp_pc + 32'd4;
                        since_acc = 0;
                        total_acc++;
                    end
                end
            end
            if (since_acc > max_gap) max_gap = since_acc;
            if (bus_req_valid && bus_req_ready) begin
                chk("rnd_one_outstanding", outst, 0);
                chk("rnd_req_addr", bus_req_addr, exp_pc & ~AW'(PN * 4 - 1));
                outst    = 1;
                out_addr = bus_req_addr;
                rcnt     = $urandom_range(1, 3);
            end
        end
        chk("rnd_progress_total", total_acc >= 1000, 1'b1);
        chk("rnd_max_gap", max_gap < 400, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
